// File: rtl/mimc_hash_ctrl_if.sv
// Bundle of message, digest, cipher and status signals shared by the MiMC hash
// controller and its environment.
interface mimc_hash_ctrl_if #(
  parameter int N_BITS = 254,
  parameter int CNT_W  = 16
);
  logic              msg_valid;
  logic              msg_ready;
  logic [N_BITS-1:0] msg_data;
  logic              msg_last;
  logic              digest_valid;
  logic              digest_ready;
  logic [N_BITS-1:0] digest;
  logic              cipher_en;
  logic [N_BITS-1:0] cipher_in;
  logic [N_BITS-1:0] cipher_key;
  logic [N_BITS-1:0] cipher_out;
  logic              cipher_done;
  logic              busy;
  logic [CNT_W-1:0]  block_cnt;

  modport slave (
    input  msg_valid, msg_data, msg_last, digest_ready, cipher_out, cipher_done,
    output msg_ready, digest_valid, digest, cipher_en, cipher_in, cipher_key,
           busy, block_cnt
  );

  modport master (
    output msg_valid, msg_data, msg_last, digest_ready, cipher_out, cipher_done,
    input  msg_ready, digest_valid, digest, cipher_en, cipher_in, cipher_key,
           busy, block_cnt
  );
endinterface

// File: rtl/mimc_hash_ctrl.sv
// Miyaguchi-Preneel MiMC hash controller: h_new = (E_h(m) + m + h) mod p per element.
// Define MIMC_HASH_INPUT_REDUCE_EN to reduce msg_data modulo p when it is captured.
module mimc_hash_ctrl #(
  parameter int                N_BITS  = 254,
  parameter logic [N_BITS-1:0] MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter logic [N_BITS-1:0] IV      = '0,
  parameter int                CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  mimc_hash_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_ADD1, S_ADD2, S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] h_q, h_d;
  logic [N_BITS-1:0] m_q, m_d;
  logic [N_BITS-1:0] c_q, c_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] m_cap;
  logic [N_BITS-1:0] m_add;

  // Operands are below p, so the N_BITS+1 bit sum needs at most one subtraction.
  function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, MODULUS}) s = s - {1'b0, MODULUS};
    return s[N_BITS-1:0];
  endfunction

  function automatic logic [N_BITS-1:0] reduce_once(input logic [N_BITS-1:0] x);
    return (x >= MODULUS) ? (x - MODULUS) : x;
  endfunction

`ifdef MIMC_HASH_INPUT_REDUCE_EN
  assign m_cap = reduce_once(bus.msg_data);
  assign m_add = m_q;
`else
  // Raw m may exceed p; canonicalise it before the add so t stays below p.
  assign m_cap = bus.msg_data;
  assign m_add = reduce_once(m_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      h_q     <= IV;
      m_q     <= '0;
      c_q     <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      c_q     <= c_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    h_d              = h_q;
    m_d              = m_q;
    c_d              = c_q;
    last_d           = last_q;
    cnt_d            = cnt_q;
    bus.msg_ready    = 1'b0;
    bus.digest_valid = 1'b0;
    bus.digest       = '0;
    bus.cipher_en    = 1'b0;
    bus.cipher_in    = m_q;
    bus.cipher_key   = h_q;
    bus.busy         = (state_q != S_IDLE);
    bus.block_cnt    = cnt_q;

    case (state_q)
      S_IDLE: begin
        bus.msg_ready = 1'b1;
        if (bus.msg_valid) begin
          m_d     = m_cap;
          last_d  = bus.msg_last;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        bus.cipher_en = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cipher_done) begin
          c_d     = bus.cipher_out;
          state_d = S_ADD1;
        end
      end
      // c_q is reused to hold t = c + m between the two add cycles.
      S_ADD1: begin
        c_d     = mod_add(c_q, m_add);
        state_d = S_ADD2;
      end
      S_ADD2: begin
        h_d     = mod_add(c_q, h_q);
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        bus.digest_valid = 1'b1;
        bus.digest       = h_q;
        if (bus.digest_ready) begin
          h_d     = IV;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
